// File: rtl/usb_mem_reader.sv
// Reads a byte range from the USB packet RAM word port and emits it as a byte stream.
// Define USB_MEM_READER_PREFETCH_EN for two word slots (read-ahead); default is one slot.
module usb_mem_reader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  start_addr,
    input  logic [10:0] length,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        avalid,
    output logic        awe,
    output logic [7:0]  aaddr,
    output logic [31:0] adata,
    output logic [3:0]  astrb,
    input  logic        bvalid,
    input  logic [31:0] bdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready
);

`ifdef USB_MEM_READER_PREFETCH_EN
    localparam logic [1:0] SLOTS = 2'd2;
`else
    localparam logic [1:0] SLOTS = 2'd1;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    logic        pend;
    logic [1:0]  fill;
    logic [7:0]  word_addr;
    logic [10:0] words_left;
    logic [10:0] bytes_left;
    logic [1:0]  byte_idx;
    logic        done_r;
    logic [31:0] slot0, slot1;
    logic [10:0] span;

    logic avalid_c, out_valid_c, hs, push, pop, finish, wr_idx;

    // Words spanned by the range, counting the partial leading word.
    assign span = {9'd0, start_addr[1:0]} + length + 11'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        avalid_c    = 1'b0;
        out_valid_c = 1'b0;
        hs          = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        finish      = 1'b0;
        if (state == RUN) begin
            avalid_c    = !pend && (fill < SLOTS) && (words_left != 11'd0);
            out_valid_c = (fill != 2'd0);
            hs          = out_valid_c && out_ready;
            push        = pend && bvalid;
            pop         = hs && ((byte_idx == 2'd3) || (bytes_left == 11'd1));
            finish      = hs && (bytes_left == 11'd1);
            if (finish) state_next = IDLE;
        end else if (start && (length != 11'd0)) begin
            state_next = RUN;
        end
        if (abort) state_next = IDLE;
    end

    // A response lands behind the word still left after this cycle's pop.
    assign wr_idx = fill[0] & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= 1'b0;
            fill       <= 2'd0;
            word_addr  <= 8'd0;
            words_left <= 11'd0;
            bytes_left <= 11'd0;
            byte_idx   <= 2'd0;
            done_r     <= 1'b0;
        end else if (abort) begin
            pend   <= 1'b0;
            fill   <= 2'd0;
            done_r <= 1'b0;
        end else begin
            done_r <= finish;
            if (state == IDLE) begin
                pend <= 1'b0;
                if (start) begin
                    if (length == 11'd0) done_r <= 1'b1;
                    word_addr  <= start_addr[9:2];
                    words_left <= span >> 2;
                    bytes_left <= length;
                    byte_idx   <= start_addr[1:0];
                    fill       <= 2'd0;
                end
            end else begin
                if (avalid_c) begin
                    pend       <= 1'b1;
                    word_addr  <= word_addr + 8'd1;
                    words_left <= words_left - 11'd1;
                end else if (push) begin
                    pend <= 1'b0;
                end
                fill <= fill + {1'b0, push} - {1'b0, pop};
                if (hs) begin
                    bytes_left <= bytes_left - 11'd1;
                    byte_idx   <= byte_idx + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) slot0 <= slot1;
        if (push) begin
            if (wr_idx) slot1 <= bdata;
            else        slot0 <= bdata;
        end
    end

    assign busy      = (state == RUN);
    assign done      = done_r;
    assign avalid    = avalid_c;
    assign aaddr     = avalid_c ? word_addr : 8'h00;
    assign awe       = 1'b0;
    assign adata     = 32'h0;
    assign astrb     = 4'h0;
    assign out_valid = out_valid_c;
    assign out_data  = out_valid_c ? slot0[{byte_idx, 3'b000} +: 8] : 8'h00;
    assign out_last  = out_valid_c && (bytes_left == 11'd1);

endmodule
